// File: rtl/alu_flags_6502.sv
// rtl/alu_flags_6502.sv - 6502 post-ALU stage: BCD correction, result register and status register P
// Optional feature macro: ALU_FLAGS_CMOS_NZ_EN (65C02 N/Z taken from the decimal-corrected result)
module alu_flags_6502 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RDY,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_hc,
    input  logic       alu_n,
    input  logic       alu_v,
    input  logic       alu_z,
    input  logic       adj_req,
    input  logic       adj_sub,
    input  logic       upd_nz,
    input  logic       upd_c,
    input  logic       upd_v,
    input  logic       bit_op,
    input  logic [2:0] flag_op,
    input  logic       load_p,
    input  logic       irq_set,
    input  logic [7:0] din,
    input  logic       b_flag,
    output logic [7:0] res,
    output logic       res_valid,
    output logic [7:0] P,
    output logic       D
);

    typedef enum logic [2:0] {
        FOP_NONE = 3'b000,
        FOP_SEC  = 3'b001,
        FOP_CLC  = 3'b010,
        FOP_SEI  = 3'b011,
        FOP_CLI  = 3'b100,
        FOP_SED  = 3'b101,
        FOP_CLD  = 3'b110,
        FOP_CLV  = 3'b111
    } flag_op_t;

    logic       flag_n, flag_v, flag_i, flag_z, flag_c;
    logic [3:0] lo_adj, hi_adj;
    logic [7:0] corrected, res_next;
    logic       nz_n, nz_z;
    logic       n_next, v_next, d_next, i_next, z_next, c_next;
    logic       unused_din;

    // Bits 5 and 4 of a pulled P image are not storage; they are regenerated on read.
    assign unused_din = ^din[5:4];

    // Per-nibble correction, mod 16, no carry between nibbles; -6 is added as +10.
    always_comb begin
        lo_adj = 4'h0;
        hi_adj = 4'h0;
        if (adj_sub) begin
            if (!alu_hc) lo_adj = 4'hA;
            if (!alu_co) hi_adj = 4'hA;
        end else begin
            if (alu_hc) lo_adj = 4'h6;
            if (alu_co) hi_adj = 4'h6;
        end
        corrected = {alu_out[7:4] + hi_adj, alu_out[3:0] + lo_adj};
        res_next  = adj_req ? corrected : alu_out;
    end

`ifdef ALU_FLAGS_CMOS_NZ_EN
    assign nz_n = adj_req ? res_next[7] : alu_n;
    assign nz_z = adj_req ? (res_next == 8'h00) : alu_z;
`else
    assign nz_n = alu_n;
    assign nz_z = alu_z;
`endif

    // Layered from lowest to highest priority so later assignments win.
    always_comb begin
        n_next = flag_n;
        v_next = flag_v;
        d_next = D;
        i_next = flag_i;
        z_next = flag_z;
        c_next = flag_c;

        if (upd_nz) begin
            n_next = nz_n;
            z_next = nz_z;
        end
        if (upd_c) c_next = alu_co;
        if (upd_v) v_next = alu_v;

        case (flag_op_t'(flag_op))
            FOP_SEC: c_next = 1'b1;
            FOP_CLC: c_next = 1'b0;
            FOP_SEI: i_next = 1'b1;
            FOP_CLI: i_next = 1'b0;
            FOP_SED: d_next = 1'b1;
            FOP_CLD: d_next = 1'b0;
            FOP_CLV: v_next = 1'b0;
            default: ;
        endcase

        if (bit_op) begin
            n_next = din[7];
            v_next = din[6];
            z_next = alu_z;
        end

        if (load_p) begin
            n_next = din[7];
            v_next = din[6];
            d_next = din[3];
            i_next = din[2];
            z_next = din[1];
            c_next = din[0];
        end

        if (irq_set) i_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= 8'h00;
            res_valid <= 1'b0;
            flag_n    <= 1'b0;
            flag_v    <= 1'b0;
            D         <= 1'b0;
            flag_i    <= 1'b1;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            res_valid <= RDY;
            if (RDY) begin
                res    <= res_next;
                flag_n <= n_next;
                flag_v <= v_next;
                D      <= d_next;
                flag_i <= i_next;
                flag_z <= z_next;
                flag_c <= c_next;
            end
        end
    end

    assign P = {flag_n, flag_v, 1'b1, b_flag, D, flag_i, flag_z, flag_c};

endmodule

// File: tb/tb_alu_flags_6502.sv
// tb/tb_alu_flags_6502.sv - directed plus randomized bench for alu_flags_6502 against a behavioural model
module tb_alu_flags_6502;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RDY;
    logic [7:0] alu_out;
    logic       alu_co, alu_hc, alu_n, alu_v, alu_z;
    logic       adj_req, adj_sub, upd_nz, upd_c, upd_v, bit_op;
    logic [2:0] flag_op;
    logic       load_p, irq_set;
    logic [7:0] din;
    logic       b_flag;
    logic [7:0] res;
    logic       res_valid;
    logic [7:0] P;
    logic       D;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: the architectural flags as individual booleans.
    logic [7:0] m_res;
    logic       m_valid;
    logic       m_n, m_v, m_d, m_i, m_z, m_c;
    logic [7:0] held_res, held_p;

    alu_flags_6502 dut (
        .clk(clk), .rst_n(rst_n), .RDY(RDY),
        .alu_out(alu_out), .alu_co(alu_co), .alu_hc(alu_hc), .alu_n(alu_n),
        .alu_v(alu_v), .alu_z(alu_z),
        .adj_req(adj_req), .adj_sub(adj_sub),
        .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
        .bit_op(bit_op), .flag_op(flag_op), .load_p(load_p), .irq_set(irq_set),
        .din(din), .b_flag(b_flag),
        .res(res), .res_valid(res_valid), .P(P), .D(D)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] bcd_fix(input logic [7:0] a, input logic co, input logic hc,
                                           input logic sub);
        int lo, hi;
        lo = a % 16;
        hi = a / 16;
        if (!sub) begin
            if (hc) lo = lo + 6;
            if (co) hi = hi + 6;
        end else begin
            if (!hc) lo = lo + 16 - 6;
            if (!co) hi = hi + 16 - 6;
        end
        return 8'((hi % 16) * 16 + (lo % 16));
    endfunction

    function automatic logic [7:0] model_p();
        return (m_n ? 8'h80 : 8'h00) + (m_v ? 8'h40 : 8'h00) + 8'h20 + (b_flag ? 8'h10 : 8'h00)
             + (m_d ? 8'h08 : 8'h00) + (m_i ? 8'h04 : 8'h00) + (m_z ? 8'h02 : 8'h00)
             + (m_c ? 8'h01 : 8'h00);
    endfunction

    task automatic model_reset();
        m_res = 8'h00; m_valid = 1'b0;
        m_n = 0; m_v = 0; m_d = 0; m_i = 1; m_z = 0; m_c = 0;
    endtask

    // One rising edge with the currently driven inputs; highest-priority source decides each flag.
    task automatic model_edge();
        logic [7:0] r;
        logic       nn, zz;
        m_valid = RDY;
        if (!RDY) return;
        r = adj_req ? bcd_fix(alu_out, alu_co, alu_hc, adj_sub) : alu_out;
        nn = alu_n;
        zz = alu_z;
`ifdef ALU_FLAGS_CMOS_NZ_EN
        if (adj_req) begin
            nn = r >= 8'h80;
            zz = r == 8'h00;
        end
`endif
        if (load_p) begin
            m_n = din[7]; m_v = din[6]; m_d = din[3]; m_i = din[2]; m_z = din[1]; m_c = din[0];
        end else begin
            if (bit_op) begin
                m_n = din[7]; m_v = din[6]; m_z = alu_z;
            end else if (upd_nz) begin
                m_n = nn; m_z = zz;
            end
            if (!bit_op) begin
                if (flag_op == 3'd7) m_v = 1'b0;
                else if (upd_v) m_v = alu_v;
            end
            if (flag_op == 3'd1) m_c = 1'b1;
            else if (flag_op == 3'd2) m_c = 1'b0;
            else if (upd_c) m_c = alu_co;
            if (flag_op == 3'd5) m_d = 1'b1;
            if (flag_op == 3'd6) m_d = 1'b0;
            if (flag_op == 3'd3) m_i = 1'b1;
            if (flag_op == 3'd4) m_i = 1'b0;
        end
        if (irq_set) m_i = 1'b1;
        m_res = r;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".res"}, res, m_res);
        chk({tag, ".res_valid"}, {7'd0, res_valid}, {7'd0, m_valid});
        chk({tag, ".P"}, P, model_p());
        chk({tag, ".D"}, {7'd0, D}, {7'd0, m_d});
    endtask

    task automatic idle_inputs();
        RDY = 1; alu_out = 0; alu_co = 0; alu_hc = 0; alu_n = 0; alu_v = 0; alu_z = 0;
        adj_req = 0; adj_sub = 0; upd_nz = 0; upd_c = 0; upd_v = 0; bit_op = 0;
        flag_op = 0; load_p = 0; irq_set = 0; din = 0;
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic rand_inputs();
        alu_out = 8'($urandom);
        alu_co  = 1'($urandom); alu_hc = 1'($urandom); alu_v = 1'($urandom);
        alu_n   = alu_out[7];
        alu_z   = (alu_out == 8'h00) || ($urandom_range(0, 15) == 0);
        adj_req = 1'($urandom); adj_sub = 1'($urandom);
        upd_nz  = 1'($urandom); upd_c = 1'($urandom); upd_v = 1'($urandom);
        bit_op  = ($urandom_range(0, 7) == 0);
        flag_op = 3'($urandom);
        load_p  = ($urandom_range(0, 9) == 0);
        irq_set = ($urandom_range(0, 9) == 0);
        din     = 8'($urandom);
        b_flag  = 1'($urandom);
        RDY     = ($urandom_range(0, 4) != 0);
    endtask

    initial begin
        idle_inputs();
        b_flag = 0;
        rst_n  = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset");
        chk("reset.P_const", P, 8'h24);
        @(negedge clk);
        rst_n = 1;

        // ADC decimal correction
        alu_out = 8'hAE; alu_co = 1; alu_hc = 1; alu_n = 1; alu_z = 0;
        adj_req = 1; adj_sub = 0; upd_nz = 1; upd_c = 1;
        step("adc");
        chk("adc.res_const", res, 8'h04);
        chk("adc.c_z", P & 8'h03, 8'h01);

        // SBC decimal correction
        idle_inputs();
        alu_out = 8'hF1; alu_co = 0; alu_hc = 1; alu_n = 1; alu_z = 0;
        adj_req = 1; adj_sub = 1; upd_nz = 1; upd_c = 1;
        step("sbc");
        chk("sbc.res_const", res, 8'h91);
        chk("sbc.n_c", P & 8'h81, 8'h80);

        // Binary pass-through
        idle_inputs();
        alu_out = 8'h80; alu_n = 1; alu_z = 0; upd_nz = 1;
        step("bin");
        chk("bin.res_const", res, 8'h80);
        chk("bin.n_z", P & 8'h82, 8'h80);

        // Priority: irq_set over load_p over flag_op
        idle_inputs();
        flag_op = 3'd1;
        step("sec");
        idle_inputs();
        load_p = 1; din = 8'h00; irq_set = 1; flag_op = 3'd1;
        step("prio");
        chk("prio.P_const", P, 8'h24);

        // BIT loads N/V from the bus
        idle_inputs();
        bit_op = 1; din = 8'hC0; alu_z = 1; upd_nz = 1; alu_n = 0;
        step("bit");

        // Stall: nothing moves for three cycles
        held_res = res;
        held_p   = P;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            RDY = 0; load_p = 0; b_flag = 0;
            step("stall");
            chk("stall.res_hold", res, held_res);
            chk("stall.P_hold", P, held_p);
        end
        idle_inputs();
        alu_out = 8'h3B; alu_hc = 1; adj_req = 1;
        step("resume");
        chk("resume.res_const", res, 8'h31);

        // Asynchronous reset between edges after SED
        idle_inputs();
        b_flag = 0;
        flag_op = 3'd5;
        step("sed");
        chk("sed.D", {7'd0, D}, 8'h01);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk_all("arst");
        chk("arst.P_const", P, 8'h24);
        @(negedge clk);
        rst_n = 1;

        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            step("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_flags_6502.md
# alu_flags_6502

Post-ALU stage of the 6502 core: consumes the registered ALU result and flags, applies the one-cycle decimal (BCD) correction to ADC/SBC results, and owns the processor status register P. It sits directly downstream of the ALU. It feeds the register file write-back path through `res`, and the PHP/BRK push path and branch logic through `P`.

## Interface
Parameters:
- none.

Ports:
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `RDY` in 1: global stall; when low, every register in the block holds.
- `alu_out` in 8: registered ALU result.
- `alu_co`, `alu_hc`, `alu_n`, `alu_v`, `alu_z` in 1 each: registered ALU flags.
- `adj_req` in 1: current `alu_out` is a decimal ADC/SBC result needing correction.
- `adj_sub` in 1: 1 = SBC correction, 0 = ADC correction; sampled with `adj_req`.
- `upd_nz`, `upd_c`, `upd_v` in 1 each: write the corresponding ALU flags into P.
- `bit_op` in 1: BIT instruction; N←`din[7]`, V←`din[6]`, Z←`alu_z`.
- `flag_op` in 3: 000 none, 001 SEC, 010 CLC, 011 SEI, 100 CLI, 101 SED, 110 CLD, 111 CLV.
- `load_p` in 1: PLP/RTI; load P from `din`.
- `irq_set` in 1: interrupt entry; force I=1.
- `din` in 8: data bus input.
- `b_flag` in 1: value driven on `P[4]`.
- `res` out 8: registered result; either the pass-through or the corrected value.
- `res_valid` out 1: `res` updated this cycle.
- `P` out 8: {N,V,1,`b_flag`,D,I,Z,C}.
- `D` out 1: decimal flag, routed to the ALU BCD input.

## Operation
- Result stage: a single pipeline register. On each RDY cycle, `res` ← corrected(`alu_out`) if `adj_req`, else `alu_out`. `res_valid` ← 1 on each RDY cycle, and 0 when `RDY` is low.
- Correction is nibble-wise, mod 16 per nibble, with no carry between nibbles:
  - ADC: low nibble +6 if `alu_hc`; high nibble +6 if `alu_co`.
  - SBC: low nibble −6 if !`alu_hc`; high nibble −6 if !`alu_co`.
- C comes from `alu_co` unchanged; the ALU already produces the BCD carry.
- P register holds N,V,D,I,Z,C. Bit 5 reads 1; bit 4 is `b_flag`.
- Write priority within one edge, highest first:
  - `irq_set` (I only).
  - `load_p` (all six flags from `din[7:6,3:0]`).
  - `bit_op`.
  - `flag_op` / `upd_*`.
- `flag_op` and `upd_*` touch disjoint bits in legal use. If both target C or V, `flag_op` wins.
- V update uses `alu_v`. NZ update uses `alu_n`/`alu_z` unless overridden by the Configuration section.
- Reset values:
  - `res`=0x00, `res_valid`=0.
  - N=V=D=Z=C=0, I=1, so `P`=0x24 | (`b_flag`<<4).
  - Pending-NZ state cleared.

## Timing
- Latency: `alu_*` to `res` is 1 cycle. Control inputs to the `P` update are 1 edge.
- All inputs are sampled only on rising edges with `RDY`=1. While `RDY`=0, pending state and outputs hold exactly, and `res_valid`=0.
- `D` is a direct register output. A SED/CLD affects an ALU op launched in the following cycle.
- `rst_n` assertion mid-correction: `res`, `P` and pending state go to reset values immediately. No partial update follows deassertion.
- `rst_n` deassertion is synchronised externally; the first active edge may carry a valid request.

## Configuration
- `ALU_FLAGS_CMOS_NZ_EN`:
  - Defined: 65C02 behaviour. On an `adj_req` cycle with `upd_nz`, N/Z are taken from the corrected value and written on the same edge as `res`.
  - Undefined: NMOS behaviour. N/Z always come from `alu_n`/`alu_z` (the binary result).
- C and V are unaffected by the macro.

## Test plan
- ADC decimal: `alu_out`=0xAE, `alu_co`=1, `alu_hc`=1, `adj_req`=1, `adj_sub`=0, `upd_nz`=`upd_c`=1 → `res`=0x04, C=1 next cycle. Z=0 in both builds.
- SBC decimal: `alu_out`=0xF1, `alu_co`=0, `alu_hc`=1, `adj_sub`=1 → `res`=0x91, C=0. N=1 in both builds.
- Binary pass-through: `alu_out`=0x80, `adj_req`=0, `upd_nz`=1 → `res`=0x80, N=1, Z=0.
- Priority: `load_p`=1 with `din`=0x00, `irq_set`=1, `flag_op`=SEC on the same edge → `P`=0x24 | (`b_flag`<<4): I=1, C=0.
- Stall: hold `RDY`=0 for 3 cycles while toggling `adj_req`/`flag_op` → `res` and `P` unchanged, `res_valid`=0. On resume, the correction applies to inputs present at the first `RDY`=1 edge.
- Reset mid-op: assert `rst_n`=0 asynchronously between edges after SED → `P`=0x24 (with `b_flag`=0) immediately, `res`=0x00, D=0.
